cfg_write_arbiter: RTL and testbench

//  Shares the configuration register's single write port (WREN/ABUS/DBUS) among NREQ requesters
//  (host interface, watchdog FSM, BOD calibration). Round-robin arbitration, request/ack handshake.

---
 rtl/cfg_write_arbiter_if.sv | 29 ++
 rtl/cfg_write_arbiter.sv | 136 +++++++++++++
 tb/tb_cfg_write_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_write_arbiter_if.sv
// Requester/write-port bundle for cfg_write_arbiter.
// Handshake: a requester raises REQ[i] with REQ_ADDR/REQ_DATA slice i stable and holds all three
// until it sees ACK[i] or ERR[i] (one-cycle pulses), then drops REQ[i] in the following cycle.
interface cfg_write_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]      REQ;
  logic [3*NREQ-1:0]    REQ_ADDR;
  logic [16*NREQ-1:0]   REQ_DATA;
  logic                 UNLOCK;
  logic [NREQ-1:0]      ACK;
  logic [NREQ-1:0]      ERR;
  logic                 WREN;
  logic [2:0]           ABUS;
  logic [15:0]          DBUS;
  logic                 BUSY;
  logic [7:0]           VIOL_CNT;
  logic [1:0]           STATE_DBG;

  modport master (
    output REQ, REQ_ADDR, REQ_DATA, UNLOCK,
    input  ACK, ERR, WREN, ABUS, DBUS, BUSY, VIOL_CNT, STATE_DBG
  );

  modport slave (
    input  REQ, REQ_ADDR, REQ_DATA, UNLOCK,
    output ACK, ERR, WREN, ABUS, DBUS, BUSY, VIOL_CNT, STATE_DBG
  );
endinterface

// File: rtl/cfg_write_arbiter.sv
// Round-robin arbiter for the configuration register write port, with one-shot unlock
// protection for SERVICE/BOD addresses and a saturating rejected-write counter.
module cfg_write_arbiter #(
  parameter int         NREQ       = 2,
  parameter logic [7:0] PROT_MASK  = 8'hF4,
  parameter int         UNLOCK_WIN = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  cfg_write_arbiter_if.slave   bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_n;
  logic [PW-1:0]     ptr_q, ptr_n;
  logic [PW-1:0]     gnt_q, gnt_n;
  logic [7:0]        cnt_q, cnt_n;
  logic              wren_q, wren_n;
  logic [2:0]        abus_q, abus_n;
  logic [15:0]       dbus_q, dbus_n;
  logic [NREQ-1:0]   ack_q, ack_n;
  logic [NREQ-1:0]   err_q, err_n;
  logic [7:0]        viol_q, viol_n;

  logic              found;
  logic [PW-1:0]     win;
  logic [PW-1:0]     cand;
  logic [2:0]        win_addr;
  logic [15:0]       win_data;
  logic              win_prot;
  logic              accept_prot;

  // First requester at or above PTR, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.REQ[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_addr = bus.REQ_ADDR[int'(win)*3 +: 3];
  assign win_data = bus.REQ_DATA[int'(win)*16 +: 16];
  assign win_prot = PROT_MASK[win_addr];

  always_comb begin
    state_n     = state_q;
    ptr_n       = ptr_q;
    gnt_n       = gnt_q;
    wren_n      = 1'b0;
    ack_n       = '0;
    err_n       = '0;
    abus_n      = abus_q;
    dbus_n      = dbus_q;
    viol_n      = viol_q;
    accept_prot = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          ptr_n = (win == PW'(NREQ - 1)) ? '0 : PW'(win + 1'b1);
          gnt_n = win;
          if (!win_prot || (cnt_q != 8'd0)) begin
            wren_n      = 1'b1;
            abus_n      = win_addr;
            dbus_n      = win_data;
            accept_prot = win_prot;
            state_n     = WRITE;
          end else begin
            err_n   = NREQ'(1) << win;
            viol_n  = (viol_q == 8'hFF) ? viol_q : viol_q + 8'd1;
            state_n = DONE;
          end
        end
      end
      WRITE: begin
        ack_n   = NREQ'(1) << gnt_q;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A fresh UNLOCK beats the one-shot clear; decisions above use the pre-update count.
  always_comb begin
    cnt_n = cnt_q;
    if (bus.UNLOCK)
      cnt_n = 8'(UNLOCK_WIN);
    else if (accept_prot)
      cnt_n = 8'd0;
    else if (cnt_q != 8'd0)
      cnt_n = cnt_q - 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= 8'd0;
      wren_q  <= 1'b0;
      abus_q  <= 3'd0;
      dbus_q  <= 16'd0;
      ack_q   <= '0;
      err_q   <= '0;
      viol_q  <= 8'd0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      gnt_q   <= gnt_n;
      cnt_q   <= cnt_n;
      wren_q  <= wren_n;
      abus_q  <= abus_n;
      dbus_q  <= dbus_n;
      ack_q   <= ack_n;
      err_q   <= err_n;
      viol_q  <= viol_n;
    end
  end

  assign bus.WREN      = wren_q;
  assign bus.ABUS      = abus_q;
  assign bus.DBUS      = dbus_q;
  assign bus.ACK       = ack_q;
  assign bus.ERR       = err_q;
  assign bus.VIOL_CNT  = viol_q;
  assign bus.BUSY      = (state_q != IDLE);
  assign bus.STATE_DBG = state_q;
endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench for cfg_write_arbiter: a vector table for single transactions plus
// hand-written sequences for round-robin streaming, reset mid-write, unlock timing and saturation.
module tb_cfg_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt = 0;
  int   err_cnt = 0;

  cfg_write_arbiter_if #(.NREQ(2)) bus ();

  cfg_write_arbiter #(.NREQ(2), .PROT_MASK(8'hF4), .UNLOCK_WIN(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  req;
    logic [2:0]  a0;
    logic [2:0]  a1;
    logic [15:0] d0;
    logic [15:0] d1;
    int          gap;     // cycles from UNLOCK pulse to REQ sample, -1 = no UNLOCK
    logic [1:0]  exp_oh;  // requester expected to get ACK or ERR
    logic        exp_wr;
    logic [2:0]  exp_abus;
    logic [15:0] exp_dbus;
    logic [7:0]  exp_viol;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.REQ    = '0;
    bus.UNLOCK = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    if (v.gap >= 0) begin
      bus.UNLOCK = 1'b1;
      @(negedge clk);
      bus.UNLOCK = 1'b0;
      repeat (v.gap - 1) @(negedge clk);
    end
    bus.REQ_ADDR = {v.a1, v.a0};
    bus.REQ_DATA = {v.d1, v.d0};
    bus.REQ      = v.req;
    @(negedge clk);
    if (v.exp_wr) begin
      check($sformatf("v%0d_wren", i), bus.WREN, 1);
      check($sformatf("v%0d_abus", i), bus.ABUS, v.exp_abus);
      check($sformatf("v%0d_dbus", i), bus.DBUS, v.exp_dbus);
      check($sformatf("v%0d_noack_yet", i), bus.ACK, 0);
      check($sformatf("v%0d_noerr", i), bus.ERR, 0);
    end else begin
      check($sformatf("v%0d_err", i), bus.ERR, v.exp_oh);
      check($sformatf("v%0d_nowren", i), bus.WREN, 0);
      check($sformatf("v%0d_abus_hold", i), bus.ABUS, v.exp_abus);
      check($sformatf("v%0d_dbus_hold", i), bus.DBUS, v.exp_dbus);
      check($sformatf("v%0d_viol", i), bus.VIOL_CNT, v.exp_viol);
      bus.REQ = '0;
    end
    @(negedge clk);
    if (v.exp_wr) begin
      check($sformatf("v%0d_ack", i), bus.ACK, v.exp_oh);
      check($sformatf("v%0d_wren_low", i), bus.WREN, 0);
      check($sformatf("v%0d_viol", i), bus.VIOL_CNT, v.exp_viol);
      bus.REQ = '0;
      @(negedge clk);
      check($sformatf("v%0d_ack_pulse", i), bus.ACK, 0);
    end else begin
      check($sformatf("v%0d_err_pulse", i), bus.ERR, 0);
      check($sformatf("v%0d_idle", i), bus.BUSY, 0);
    end
  endtask

  initial begin
    int miss;
    logic [1:0] exp_ack;

    //          req    a0    a1    d0        d1        gap oh     wr    abus  dbus      viol
    vecs[0] = '{2'b01, 3'd0, 3'd0, 16'h00AA, 16'h0000, -1, 2'b01, 1'b1, 3'd0, 16'h00AA, 8'd0};
    vecs[1] = '{2'b10, 3'd0, 3'd1, 16'h0000, 16'h1234, -1, 2'b10, 1'b1, 3'd1, 16'h1234, 8'd0};
    vecs[2] = '{2'b11, 3'd3, 3'd1, 16'h0303, 16'h0101, -1, 2'b01, 1'b1, 3'd3, 16'h0303, 8'd0};
    vecs[3] = '{2'b11, 3'd3, 3'd1, 16'h0303, 16'h0101, -1, 2'b10, 1'b1, 3'd1, 16'h0101, 8'd0};
    vecs[4] = '{2'b10, 3'd0, 3'd2, 16'h0000, 16'h0008, -1, 2'b10, 1'b0, 3'd1, 16'h0101, 8'd1};
    vecs[5] = '{2'b01, 3'd4, 3'd0, 16'h4444, 16'h0000,  5, 2'b01, 1'b1, 3'd4, 16'h4444, 8'd1};
    vecs[6] = '{2'b01, 3'd5, 3'd0, 16'h5555, 16'h0000, -1, 2'b01, 1'b0, 3'd4, 16'h4444, 8'd2};
    vecs[7] = '{2'b01, 3'd6, 3'd0, 16'h6666, 16'h0000, 16, 2'b01, 1'b1, 3'd6, 16'h6666, 8'd2};
    vecs[8] = '{2'b01, 3'd7, 3'd0, 16'h7777, 16'h0000, 17, 2'b01, 1'b0, 3'd6, 16'h6666, 8'd3};
    vecs[9] = '{2'b11, 3'd7, 3'd0, 16'h7777, 16'hBEEF, -1, 2'b10, 1'b1, 3'd0, 16'hBEEF, 8'd3};

    bus.REQ      = '0;
    bus.REQ_ADDR = '0;
    bus.REQ_DATA = '0;
    bus.UNLOCK   = 1'b0;
    do_reset();

    check("rst_wren", bus.WREN, 0);
    check("rst_abus", bus.ABUS, 0);
    check("rst_dbus", bus.DBUS, 0);
    check("rst_ack", bus.ACK, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_viol", bus.VIOL_CNT, 0);
    check("rst_state", bus.STATE_DBG, 0);

    for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

    // Both requesters held: grants alternate 0,1,0,1, one every third cycle.
    do_reset();
    bus.REQ_ADDR = {3'd1, 3'd0};
    bus.REQ_DATA = {16'h2222, 16'h1111};
    bus.REQ      = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp_ack = (k % 3 == 1) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check($sformatf("rr%0d_wren", k), bus.WREN, (k % 3 == 0));
      check($sformatf("rr%0d_ack", k), bus.ACK, exp_ack);
      if (k % 3 == 0) check($sformatf("rr%0d_abus", k), bus.ABUS, (k / 3) % 2);
    end
    bus.REQ = '0;

    // Reset during WRITE: strobe drops, no ACK, pointer back to requester 0.
    do_reset();
    bus.REQ_ADDR = {3'd1, 3'd0};
    bus.REQ_DATA = {16'hBBBB, 16'hAAAA};
    bus.REQ      = 2'b10;
    @(negedge clk);
    check("mid_rst_wren_before", bus.WREN, 1);
    check("mid_rst_abus_before", bus.ABUS, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wren", bus.WREN, 0);
    check("mid_rst_ack", bus.ACK, 0);
    check("mid_rst_busy", bus.BUSY, 0);
    bus.REQ = 2'b11;
    rst     = 1'b0;
    @(negedge clk);
    check("post_rst_wren", bus.WREN, 1);
    check("post_rst_abus", bus.ABUS, 0);
    check("post_rst_dbus", bus.DBUS, 16'hAAAA);
    @(negedge clk);
    check("post_rst_ack", bus.ACK, 2'b01);
    bus.REQ = '0;
    @(negedge clk);

    // UNLOCK coinciding with a protected grant.
    do_reset();
    bus.REQ_ADDR = {3'd0, 3'd2};
    bus.REQ_DATA = {16'h0000, 16'h0C0C};
    bus.REQ      = 2'b01;
    bus.UNLOCK   = 1'b1;
    @(negedge clk);
    check("unl_same_locked_err", bus.ERR, 2'b01);
    check("unl_same_locked_wren", bus.WREN, 0);
    bus.REQ    = '0;
    bus.UNLOCK = 1'b0;
    @(negedge clk);
    bus.REQ    = 2'b01;
    bus.UNLOCK = 1'b1;
    @(negedge clk);
    check("unl_same_open_wren", bus.WREN, 1);
    check("unl_same_open_abus", bus.ABUS, 2);
    bus.UNLOCK = 1'b0;
    @(negedge clk);
    check("unl_same_open_ack", bus.ACK, 2'b01);
    bus.REQ = '0;
    @(negedge clk);
    bus.REQ_ADDR = {3'd0, 3'd4};
    bus.REQ_DATA = {16'h0000, 16'h0D0D};
    bus.REQ      = 2'b01;
    @(negedge clk);
    check("unl_reload_wren", bus.WREN, 1);
    check("unl_reload_dbus", bus.DBUS, 16'h0D0D);
    @(negedge clk);
    bus.REQ = '0;
    @(negedge clk);
    bus.REQ_ADDR = {3'd0, 3'd5};
    bus.REQ      = 2'b01;
    @(negedge clk);
    check("unl_oneshot_err", bus.ERR, 2'b01);
    check("unl_oneshot_wren", bus.WREN, 0);
    bus.REQ = '0;
    @(negedge clk);

    // Saturation of the rejected-write counter.
    do_reset();
    miss         = 0;
    bus.REQ_ADDR = {3'd0, 3'd2};
    bus.REQ_DATA = {16'h0000, 16'h0008};
    for (int i = 0; i < 300; i++) begin
      bus.REQ = 2'b01;
      @(negedge clk);
      if (bus.ERR !== 2'b01 || bus.WREN !== 1'b0) miss++;
      if (i == 253) check("sat_viol_254", bus.VIOL_CNT, 8'hFE);
      bus.REQ = '0;
      @(negedge clk);
    end
    check("sat_err_misses", miss, 0);
    check("sat_viol", bus.VIOL_CNT, 8'hFF);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
